// File: rtl/lsu_arbiter.sv
// Two-port arbiter in front of a single LSU: port 0 is the core, port 1 the
// accelerator. Grants are registered (one cycle of latency from IDLE). The
// downstream request is a combinational copy of the granted port. A grant
// is held across completions while the owner asserts lock, and is dropped
// after TIMEOUT granted cycles without a completion.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | no owner; all lsu_* outputs driven to 0
//   GRANT0 | core owns the LSU; lsu_* mirror the p0_* inputs
//   GRANT1 | accelerator owns the LSU; lsu_* mirror the p1_* inputs
module lsu_arbiter #(
    parameter int RR      = 1,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_ren,
    input  logic        p0_wen,
    input  logic [1:0]  p0_type,
    input  logic [31:0] p0_addr_base,
    input  logic [31:0] p0_addr_offset,
    input  logic [31:0] p0_wdata,
    input  logic        p0_lock,
    output logic        p0_done,
    output logic [31:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_ren,
    input  logic        p1_wen,
    input  logic [1:0]  p1_type,
    input  logic [31:0] p1_addr_base,
    input  logic [31:0] p1_addr_offset,
    input  logic [31:0] p1_wdata,
    input  logic        p1_lock,
    output logic        p1_done,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    output logic        lsu_ren,
    output logic        lsu_wen,
    output logic [1:0]  lsu_type,
    output logic [31:0] lsu_addr_base,
    output logic [31:0] lsu_addr_offset,
    output logic [31:0] lsu_wdata,
    input  logic        lsu_done,
    input  logic [31:0] lsu_rdata
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_TC  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          last, last_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic req0, req1;
    logic granted;
    logic sel_req, sel_lock;
    logic timeout;
    logic rel;
    logic kill_req;

    // With both ports requesting, round-robin hands the grant to whichever
    // port did not hold it most recently; fixed priority always picks port 0.
    function automatic state_t decide(input logic r0, input logic r1, input logic lst);
        state_t s;
        if (r0 && r1) begin
            s = ((RR != 0) && (lst == 1'b0)) ? GRANT1 : GRANT0;
        end else if (r0) begin
            s = GRANT0;
        end else if (r1) begin
            s = GRANT1;
        end else begin
            s = IDLE;
        end
        return s;
    endfunction

    assign req0 = p0_ren | p0_wen;
    assign req1 = p1_ren | p1_wen;

    // Next-state, last-granted and timeout-counter logic.
    always_comb begin
        granted   = (state != IDLE);
        sel_req   = (state == GRANT1) ? req1    : req0;
        sel_lock  = (state == GRANT1) ? p1_lock : p0_lock;
        // A completion in the same cycle takes precedence over the timeout.
        timeout   = granted && (cnt == CNT_TC) && !lsu_done;
        // Timeout releases even a locked owner.
        rel       = granted && ((lsu_done && !sel_lock) || (!sel_req && !sel_lock) || timeout);

        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = cnt;

        if (state == IDLE) begin
            state_nxt = decide(req0, req1, last);
        end else if (rel) begin
            // Re-arbitrate immediately with the releasing port as most recent.
            state_nxt = decide(req0, req1, state == GRANT1);
        end

        if (state_nxt == GRANT0) begin
            last_nxt = 1'b0;
        end else if (state_nxt == GRANT1) begin
            last_nxt = 1'b1;
        end

        // Every release starts a fresh grant, even one back to the same port.
        if ((state_nxt != state) || lsu_done || rel) begin
            cnt_nxt = '0;
        end else if (granted && (cnt != CNT_MAX)) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // State, last-granted and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Output steering: mirror the owner downstream, route completion back.
    always_comb begin
        kill_req        = lsu_done | timeout;
        lsu_ren         = 1'b0;
        lsu_wen         = 1'b0;
        lsu_type        = 2'd0;
        lsu_addr_base   = 32'd0;
        lsu_addr_offset = 32'd0;
        lsu_wdata       = 32'd0;
        p0_done         = 1'b0;
        p0_rdata        = 32'd0;
        p0_err          = 1'b0;
        p1_done         = 1'b0;
        p1_rdata        = 32'd0;
        p1_err          = 1'b0;

        case (state)
            GRANT0: begin
                lsu_ren         = p0_ren & ~kill_req;
                lsu_wen         = p0_wen & ~kill_req;
                lsu_type        = p0_type;
                lsu_addr_base   = p0_addr_base;
                lsu_addr_offset = p0_addr_offset;
                lsu_wdata       = p0_wdata;
                p0_done         = lsu_done;
                p0_rdata        = lsu_rdata;
                p0_err          = timeout;
            end
            GRANT1: begin
                lsu_ren         = p1_ren & ~kill_req;
                lsu_wen         = p1_wen & ~kill_req;
                lsu_type        = p1_type;
                lsu_addr_base   = p1_addr_base;
                lsu_addr_offset = p1_addr_offset;
                lsu_wdata       = p1_wdata;
                p1_done         = lsu_done;
                p1_rdata        = lsu_rdata;
                p1_err          = timeout;
            end
            default: begin
            end
        endcase
    end

endmodule
